chal_mem: RTL and testbench

//  Word-organised (16-bit) single-port RAM holding the attestation challenge in the CFA metadata block.

---
 rtl/chal_mem_pkg.sv | 31 +++
 rtl/chal_mem_if.sv | 31 +++
 rtl/chal_mem.sv | 72 +++++++
 tb/tb_chal_mem.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/chal_mem_pkg.sv
// Shared constants, write-enable encodings and byte-lane merge helper for the
// CFA attestation-challenge RAM.
package chal_mem_pkg;

  localparam int unsigned CHAL_ADDR_MSB = 3;
  localparam int unsigned CHAL_SIZE     = 32;
  localparam int unsigned CHAL_WORDS    = CHAL_SIZE / 2;
  localparam int unsigned CHAL_DATA_W   = 16;

  // Byte write enables are active-low: bit0 = low lane, bit1 = high lane.
  typedef enum logic [1:0] {
    WEN_WORD = 2'b00,
    WEN_HI   = 2'b01,
    WEN_LO   = 2'b10,
    WEN_NONE = 2'b11
  } wen_e;

  // Replace only the lanes whose active-low enable is asserted.
  function automatic logic [CHAL_DATA_W-1:0] lane_merge(
    input logic [CHAL_DATA_W-1:0] old_word,
    input logic [CHAL_DATA_W-1:0] new_word,
    input logic [1:0]             wen_n
  );
    logic [CHAL_DATA_W-1:0] merged;
    merged = old_word;
    if (!wen_n[0]) merged[7:0]  = new_word[7:0];
    if (!wen_n[1]) merged[15:8] = new_word[15:8];
    return merged;
  endfunction

endpackage

// File: rtl/chal_mem_if.sv
// Peripheral-decoder to challenge-RAM bus: word address, low-active strobes,
// write data in, read data out.
interface chal_mem_if
  import chal_mem_pkg::*;
#(
  parameter int unsigned ADDR_MSB = CHAL_ADDR_MSB
);

  logic [ADDR_MSB:0]      ram_addr;
  logic                   ram_cen;
  logic [CHAL_DATA_W-1:0] ram_din;
  logic [1:0]             ram_wen;
  logic [CHAL_DATA_W-1:0] ram_dout;

  modport master (
    output ram_addr,
    output ram_cen,
    output ram_din,
    output ram_wen,
    input  ram_dout
  );

  modport slave (
    input  ram_addr,
    input  ram_cen,
    input  ram_din,
    input  ram_wen,
    output ram_dout
  );

endinterface

// File: rtl/chal_mem.sv
// Attestation-challenge RAM: 16-bit words, byte-lane writes, openMSP430 read timing.
// Optional macro CHAL_MEM_RST_CLR_EN: puc_rst also wipes every word.
module chal_mem
  import chal_mem_pkg::*;
#(
  parameter int unsigned ADDR_MSB = CHAL_ADDR_MSB,
  parameter int unsigned MEM_SIZE = CHAL_SIZE
) (
  input  logic       mclk,
  input  logic       puc_rst,
  chal_mem_if.slave  mem_if
);

  localparam int unsigned DEPTH = MEM_SIZE / 2;

  logic [ADDR_MSB:0]      addr_q;
  logic [ADDR_MSB:0]      addr_d;
  logic                   access_c;
  logic                   wr_en_c;
  logic [CHAL_DATA_W-1:0] wr_word_c;

`ifdef CHAL_MEM_RST_CLR_EN
  logic [CHAL_DATA_W-1:0] mem_q [DEPTH];
`else
  logic [CHAL_DATA_W-1:0] mem_q [DEPTH] = '{default: '0};
`endif

  // Access decode: enabled and inside the populated word range.
  always_comb begin
    access_c  = 1'b0;
    wr_en_c   = 1'b0;
    addr_d    = addr_q;
    wr_word_c = '0;
    if (!mem_if.ram_cen && (32'(mem_if.ram_addr) < DEPTH)) begin
      access_c  = 1'b1;
      addr_d    = mem_if.ram_addr;
      wr_en_c   = (mem_if.ram_wen != WEN_NONE);
      wr_word_c = lane_merge(mem_q[mem_if.ram_addr], mem_if.ram_din, mem_if.ram_wen);
    end
  end

  // Read address register; reset points the output at word 0.
  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) begin
      addr_q <= '0;
    end else if (access_c) begin
      addr_q <= addr_d;
    end
  end

`ifdef CHAL_MEM_RST_CLR_EN
  // Storage with asynchronous wipe so a challenge cannot survive a PUC.
  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) begin
      mem_q <= '{default: '0};
    end else if (wr_en_c) begin
      mem_q[addr_d] <= wr_word_c;
    end
  end
`else
  // Storage retained across reset; a write coinciding with reset is dropped.
  always_ff @(posedge mclk) begin
    if (wr_en_c && !puc_rst) begin
      mem_q[addr_d] <= wr_word_c;
    end
  end
`endif

  // Combinational read from the registered address gives write-first behaviour.
  assign mem_if.ram_dout = mem_q[addr_q];

endmodule

// File: tb/tb_chal_mem.sv
// Self-checking bench for chal_mem: directed scenarios plus randomized traffic
// against a word-array reference model.
module tb_chal_mem;
  import chal_mem_pkg::*;

  localparam int unsigned WORDS = CHAL_WORDS;

  logic mclk;
  logic puc_rst;

  chal_mem_if #(.ADDR_MSB(CHAL_ADDR_MSB)) bus ();

  chal_mem #(.ADDR_MSB(CHAL_ADDR_MSB), .MEM_SIZE(CHAL_SIZE)) dut (
    .mclk    (mclk),
    .puc_rst (puc_rst),
    .mem_if  (bus)
  );

  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  // Reference model: word contents and the word the output currently shows.
  logic [15:0] exp_mem [WORDS];
  int unsigned exp_addr;
  int          checks;
  int          fails;

  task automatic model_reset();
    exp_addr = 0;
`ifdef CHAL_MEM_RST_CLR_EN
    for (int i = 0; i < int'(WORDS); i++) exp_mem[i] = 16'h0000;
`endif
  endtask

  // One bus cycle: drive, take the edge, update model, settle 1 time unit past edge.
  task automatic cycle(input logic [3:0] a, input logic cen, input logic [15:0] d,
                       input logic [1:0] wen);
    bus.ram_addr = a;
    bus.ram_cen  = cen;
    bus.ram_din  = d;
    bus.ram_wen  = wen;
    @(posedge mclk);
    if (puc_rst) begin
      model_reset();
    end else if (!cen && int'(a) < int'(WORDS)) begin
      if (!wen[0]) exp_mem[a][7:0]  = d[7:0];
      if (!wen[1]) exp_mem[a][15:8] = d[15:8];
      exp_addr = int'(a);
    end
    #1;
  endtask

  task automatic test_reset();
    puc_rst = 1'b1;
    model_reset();
    repeat (3) cycle(4'd0, 1'b1, 16'h0000, WEN_NONE);
    checks++;
    if (bus.ram_dout !== 16'h0000) begin
      fails++;
      $display("FAIL reset_hold: dout=%h expected=%h", bus.ram_dout, 16'h0000);
    end
    puc_rst = 1'b0;
    cycle(4'd0, 1'b0, 16'h0000, WEN_NONE);
    checks++;
    if (bus.ram_dout !== 16'h0000) begin
      fails++;
      $display("FAIL reset_read0: dout=%h expected=%h", bus.ram_dout, 16'h0000);
    end
  endtask

  task automatic test_full_write();
    cycle(4'd3, 1'b0, 16'hA5C3, WEN_WORD);
    checks++;
    if (bus.ram_dout !== 16'hA5C3) begin
      fails++;
      $display("FAIL write_first: dout=%h expected=%h", bus.ram_dout, 16'hA5C3);
    end
    cycle(4'd0, 1'b0, 16'h0000, WEN_NONE);
    cycle(4'd3, 1'b0, 16'hFFFF, WEN_NONE);
    checks++;
    if (bus.ram_dout !== 16'hA5C3) begin
      fails++;
      $display("FAIL full_read: dout=%h expected=%h", bus.ram_dout, 16'hA5C3);
    end
  endtask

  task automatic test_byte_lanes();
    cycle(4'd5, 1'b0, 16'h1234, WEN_WORD);
    cycle(4'd5, 1'b0, 16'hFFAB, WEN_LO);
    checks++;
    if (bus.ram_dout !== 16'h12AB) begin
      fails++;
      $display("FAIL lane_lo: dout=%h expected=%h", bus.ram_dout, 16'h12AB);
    end
    cycle(4'd5, 1'b0, 16'hCDFF, WEN_HI);
    checks++;
    if (bus.ram_dout !== 16'hCDAB) begin
      fails++;
      $display("FAIL lane_hi: dout=%h expected=%h", bus.ram_dout, 16'hCDAB);
    end
  endtask

  task automatic test_cen_idle();
    cycle(4'd15, 1'b1, 16'hBEEF, WEN_WORD);
    checks++;
    if (bus.ram_dout !== 16'hCDAB) begin
      fails++;
      $display("FAIL cen_hold_addr: dout=%h expected=%h", bus.ram_dout, 16'hCDAB);
    end
    repeat (3) cycle(4'($urandom_range(0, 15)), 1'b1, 16'($urandom), 2'($urandom));
    checks++;
    if (bus.ram_dout !== 16'hCDAB) begin
      fails++;
      $display("FAIL cen_idle: dout=%h expected=%h", bus.ram_dout, 16'hCDAB);
    end
    cycle(4'd15, 1'b0, 16'h0000, WEN_NONE);
    checks++;
    if (bus.ram_dout !== 16'h0000) begin
      fails++;
      $display("FAIL cen_no_write: dout=%h expected=%h", bus.ram_dout, 16'h0000);
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 16; i++) cycle(4'(i), 1'b0, 16'h0100 + 16'(i), WEN_WORD);
    for (int i = 0; i < 16; i++) begin
      cycle(4'(i), 1'b0, 16'hDEAD, WEN_NONE);
      checks++;
      if (bus.ram_dout !== 16'h0100 + 16'(i)) begin
        fails++;
        $display("FAIL fill_word%0d: dout=%h expected=%h", i, bus.ram_dout, 16'h0100 + 16'(i));
      end
    end
  endtask

  task automatic test_reset_retention();
    logic [15:0] want;
    cycle(4'd7, 1'b0, 16'h5555, WEN_WORD);
    cycle(4'd9, 1'b0, 16'h1111, WEN_WORD);
    puc_rst = 1'b1;
    model_reset();
    cycle(4'd9, 1'b0, 16'h2222, WEN_WORD);
    checks++;
    if (bus.ram_dout !== exp_mem[0]) begin
      fails++;
      $display("FAIL rst_addr0: dout=%h expected=%h", bus.ram_dout, exp_mem[0]);
    end
    puc_rst = 1'b0;
`ifdef CHAL_MEM_RST_CLR_EN
    want = 16'h0000;
`else
    want = 16'h5555;
`endif
    cycle(4'd7, 1'b0, 16'h0000, WEN_NONE);
    checks++;
    if (bus.ram_dout !== want) begin
      fails++;
      $display("FAIL rst_keep7: dout=%h expected=%h", bus.ram_dout, want);
    end
`ifdef CHAL_MEM_RST_CLR_EN
    want = 16'h0000;
`else
    want = 16'h1111;
`endif
    cycle(4'd9, 1'b0, 16'h0000, WEN_NONE);
    checks++;
    if (bus.ram_dout !== want) begin
      fails++;
      $display("FAIL rst_midwrite: dout=%h expected=%h", bus.ram_dout, want);
    end
  endtask

  task automatic test_random();
    int bad;
    bad = 0;
    for (int n = 0; n < 400; n++) begin
      cycle(4'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0), 16'($urandom),
            2'($urandom));
      checks++;
      if (bus.ram_dout !== exp_mem[exp_addr]) begin
        fails++;
        if (bad < 5)
          $display("FAIL random_%0d: dout=%h expected=%h", n, bus.ram_dout, exp_mem[exp_addr]);
        bad++;
      end
    end
    for (int i = 0; i < 16; i++) begin
      cycle(4'(i), 1'b0, 16'h0000, WEN_NONE);
      checks++;
      if (bus.ram_dout !== exp_mem[i]) begin
        fails++;
        $display("FAIL sweep_word%0d: dout=%h expected=%h", i, bus.ram_dout, exp_mem[i]);
      end
    end
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    for (int i = 0; i < int'(WORDS); i++) exp_mem[i] = 16'h0000;
    exp_addr     = 0;
    puc_rst      = 1'b1;
    bus.ram_addr = '0;
    bus.ram_cen  = 1'b1;
    bus.ram_din  = '0;
    bus.ram_wen  = WEN_NONE;

    test_reset();
    test_full_write();
    test_byte_lanes();
    test_cen_idle();
    test_fill();
    test_reset_retention();
    test_random();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
